// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//   Host-side coefficient programmer for the FIR core. It takes NTAPS
//   coefficient words from a valid/ready stream and presents them on cin/caddr
//   while holding cload high. cload stays high for HOLD_CYC extra cycles after
//   the last word and then falls, which lets the core start filtering. The
//   block reports completion, abort and a 16-bit running checksum.
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int NTAPS    = 64,
   parameter int DW       = 16,
   parameter int AW       = $clog2(NTAPS),
   parameter int HOLD_CYC = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          abort,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic [DW-1:0] cin,
   output logic [AW-1:0] caddr,
   output logic          cload,
   output logic          busy,
   output logic          load_done,
   output logic          aborted,
   output logic [15:0]   checksum
);

   // The hold counter has to reach HOLD_CYC, so size it for that value.
   localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] count;     // address of the next word to accept
   logic [HW-1:0] hold_cnt;  // cycles already spent in HOLD

   // Word accepted on this edge: handshake complete and no abort pending.
   logic accept;
   assign accept = (state == ST_LOAD) && s_valid && s_ready && !abort;

   // Abort only has meaning while the load window is open.
   logic abort_hit;
   assign abort_hit = abort && ((state == ST_LOAD) || (state == ST_HOLD));

   // FSM with every output registered; pulses default low each cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the async reset clears every output register, so cload drops
         // the moment rstn falls, without waiting for a clock edge.
         state     <= ST_IDLE;
         count     <= '0;
         hold_cnt  <= '0;
         s_ready   <= 1'b0;
         cin       <= '0;
         caddr     <= '0;
         cload     <= 1'b0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         aborted   <= 1'b0;
         checksum  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge value of state/count and none sees a half-updated one.
         load_done <= 1'b0;
         aborted   <= 1'b0;

         if (abort_hit) begin
            // Close the window at once; the word on the bus this cycle is dropped.
            state   <= ST_IDLE;
            cload   <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b0;
            aborted <= 1'b1;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     state    <= ST_LOAD;
                     cload    <= 1'b1;
                     busy     <= 1'b1;
                     s_ready  <= 1'b1;
                     count    <= '0;
                     caddr    <= '0;
                     checksum <= '0;
                  end
               end

               ST_LOAD: begin
                  if (accept) begin
                     cin      <= s_data;
                     caddr    <= count;
                     checksum <= checksum + 16'(s_data);
                     if (count == LAST_ADDR) begin
                        // Last word: stop accepting and keep it on the bus.
                        // count stays at LAST_ADDR so it never wraps.
                        s_ready  <= 1'b0;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                     end else begin
                        count <= count + AW'(1);
                     end
                  end
               end

               ST_HOLD: begin
                  // HOLD lasts HOLD_CYC+1 cycles, so the last word is seen
                  // with cload high for that many cycles in total.
                  if (hold_cnt == HOLD_LAST) begin
                     state     <= ST_FIN;
                     cload     <= 1'b0;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end

               ST_FIN: begin
                  state <= ST_IDLE;
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol properties of the cload window
   // ---------------------------------------------------------------------------

   // busy and cload describe the same window.
   a_busy_is_window: assert property (@(posedge clk) disable iff (!rstn)
      busy == cload);

   // Words are only taken while the window is open.
   a_ready_in_window: assert property (@(posedge clk) disable iff (!rstn)
      s_ready |-> cload);

   // Completion and abort are mutually exclusive.
   a_one_pulse: assert property (@(posedge clk) disable iff (!rstn)
      !(load_done && aborted));

   // cload only ever closes by completing or by aborting.
   a_clean_fall: assert property (@(posedge clk) disable iff (!rstn)
      $fell(cload) |-> (load_done || aborted));

   // The address never runs past the last tap.
   a_addr_bound: assert property (@(posedge clk) disable iff (!rstn)
      caddr <= LAST_ADDR);

endmodule

// File: tb/tb_fir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_loader
//   Directed bench for fir_coef_loader. A transaction-level model predicts all
//   outputs each cycle; a compare process checks them on the falling edge.
//   A small FIR-side memory captures what the core would actually store while
//   cload is high, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_fir_coef_loader;

   localparam int NTAPS    = 64;
   localparam int DW       = 16;
   localparam int AW       = 6;
   localparam int HOLD_CYC = 2;

   logic          clk;
   logic          rstn;
   logic          start;
   logic          abort;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [DW-1:0] cin;
   logic [AW-1:0] caddr;
   logic          cload;
   logic          busy;
   logic          load_done;
   logic          aborted;
   logic [15:0]   checksum;

   fir_coef_loader #(
      .NTAPS(NTAPS), .DW(DW), .AW(AW), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .cin(cin), .caddr(caddr), .cload(cload), .busy(busy),
      .load_done(load_done), .aborted(aborted), .checksum(checksum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: phase of the load, words taken, hold cycles left.
   // ---------------------------------------------------------------------------
   typedef enum {P_IDLE, P_LOAD, P_HOLD, P_FIN} phase_t;

   phase_t      ph;
   int          m_words;
   int          hold_left;
   logic        e_ready, e_cload, e_busy, e_done, e_abt;
   logic [15:0] e_cin, e_sum;
   logic [5:0]  e_caddr;

   task automatic model_step();
      if (!rstn) begin
         ph = P_IDLE; m_words = 0; hold_left = 0;
         e_ready = 0; e_cload = 0; e_busy = 0; e_done = 0; e_abt = 0;
         e_cin = 0; e_caddr = 0; e_sum = 0;
         return;
      end
      e_done = 0;
      e_abt  = 0;
      if ((ph == P_LOAD || ph == P_HOLD) && abort) begin
         ph = P_IDLE; e_cload = 0; e_ready = 0; e_busy = 0; e_abt = 1;
         return;
      end
      case (ph)
         P_IDLE: if (start && !abort) begin
            ph = P_LOAD; m_words = 0;
            e_cload = 1; e_busy = 1; e_ready = 1; e_caddr = 0; e_sum = 0;
         end
         P_LOAD: if (s_valid) begin
            e_cin   = s_data;
            e_caddr = m_words[5:0];
            e_sum   = e_sum + s_data;
            m_words = m_words + 1;
            if (m_words == NTAPS) begin
               ph = P_HOLD; e_ready = 0; hold_left = HOLD_CYC;
            end
         end
         P_HOLD: if (hold_left == 0) begin
            ph = P_FIN; e_cload = 0; e_busy = 0; e_done = 1;
         end else begin
            hold_left = hold_left - 1;
         end
         P_FIN: ph = P_IDLE;
         default: ph = P_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      model_step();
   end

   // Compare DUT against model on every falling edge out of reset.
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         check("s_ready",   s_ready,   e_ready);
         check("cin",       cin,       e_cin);
         check("caddr",     caddr,     e_caddr);
         check("cload",     cload,     e_cload);
         check("busy",      busy,      e_busy);
         check("load_done", load_done, e_done);
         check("aborted",   aborted,   e_abt);
         check("checksum",  checksum,  e_sum);
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: cycle counter, pulse counts, cload statistics, FIR-side memory.
   // ---------------------------------------------------------------------------
   int          cyc_cnt = 0;
   int          start_cyc, last_done_cyc;
   int          done_cnt, abt_cnt, cl_total, last_pres, fall_cnt, bad_fall;
   logic [15:0] last_done_sum;
   logic        prev_cload = 1'b0;
   logic [15:0] fir_mem [NTAPS];

   initial forever begin
      @(posedge clk);
      cyc_cnt++;
   end

   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (load_done) begin
            done_cnt++;
            last_done_cyc = cyc_cnt;
            last_done_sum = checksum;
         end
         if (aborted) abt_cnt++;
         if (cload) begin
            cl_total++;
            fir_mem[caddr] = cin;
            if (caddr == AW'(NTAPS - 1)) last_pres++;
         end
         if (prev_cload && !cload) begin
            fall_cnt++;
            if (!load_done && !aborted) bad_fall++;
         end
      end
      prev_cload = cload;
   end

   task automatic clear_stats();
      done_cnt = 0; abt_cnt = 0; cl_total = 0; last_pres = 0;
      fall_cnt = 0; bad_fall = 0; last_done_sum = 0;
      for (int i = 0; i < NTAPS; i++) fir_mem[i] = 16'h0000;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [15:0] words [NTAPS];

   task automatic fill_ramp();
      for (int i = 0; i < NTAPS; i++) words[i] = 16'(i + 1);
   endtask

   task automatic do_start();
      @(negedge clk);
      start     = 1'b1;
      start_cyc = cyc_cnt;
   endtask

   // Stream n words; optional idle gaps, abort before word abort_at,
   // and a stray start pulse while presenting word restart_at.
   task automatic send_stream(input int n, input bit gaps, input int abort_at,
                              input int restart_at);
      int k   = 0;
      int cyc = 0;
      bit acc;
      bit restarted = 0;
      while (k < n) begin
         if (cyc > 400) begin
            check("stream_budget", k, n);
            return;
         end
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (k == abort_at) begin
            abort   = 1'b1;
            s_valid = 1'b1;
            s_data  = words[k];
            @(negedge clk);
            abort   = 1'b0;
            s_valid = 1'b0;
            return;
         end
         if (k == restart_at && !restarted) begin
            start     = 1'b1;
            restarted = 1;
         end
         if (gaps && (cyc % 2 == 1)) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = words[k];
         end
         acc = s_valid && s_ready;
         @(posedge clk);
         if (acc) k++;
         cyc++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      start   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c  = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) check("done_timeout", c, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_ramp(input string tag);
      for (int i = 0; i < NTAPS; i++)
         check($sformatf("%s_mem[%0d]", tag, i), fir_mem[i], 16'(i + 1));
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("rst_cload", cload, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", s_ready, 0);
      check("rst_checksum", checksum, 0);
      rstn = 1'b1;
      idle(2);
      check("idle_caddr", caddr, 0);
      check("idle_cin", cin, 0);
      check("idle_done", load_done, 0);

      // T1: back-to-back ramp 1..64
      clear_stats();
      fill_ramp();
      do_start();
      send_stream(NTAPS, 0, -1, -1);
      wait_done(20);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_abt_cnt", abt_cnt, 0);
      check("t1_checksum", last_done_sum, 16'h0820);
      check("t1_latency", last_done_cyc - start_cyc, 68);
      // One setup cycle with no word yet, then 64+HOLD_CYC cycles presenting words.
      check("t1_cload_word_cycles", cl_total - 1, 66);
      check("t1_last_word_cycles", last_pres, 3);
      check("t1_mem0", fir_mem[0], 16'd1);
      check("t1_mem63", fir_mem[63], 16'd64);
      check_ramp("t1");
      idle(3);

      // T2: same stream, valid low every other cycle
      clear_stats();
      do_start();
      send_stream(NTAPS, 1, -1, -1);
      wait_done(20);
      check("t2_done_cnt", done_cnt, 1);
      check("t2_checksum", last_done_sum, 16'h0820);
      check("t2_cload_falls", fall_cnt, 1);
      check("t2_bad_fall", bad_fall, 0);
      check_ramp("t2");
      idle(3);

      // T3: abort after 10 accepted words, then a clean reload
      clear_stats();
      do_start();
      send_stream(NTAPS, 0, 10, -1);
      check("t3_cload_after_abort", cload, 0);
      check("t3_aborted_pulse", aborted, 1);
      idle(3);
      check("t3_abt_cnt", abt_cnt, 1);
      check("t3_done_cnt", done_cnt, 0);
      check("t3_checksum", checksum, 16'd55);
      check("t3_caddr", caddr, 9);
      clear_stats();
      do_start();
      send_stream(NTAPS, 0, -1, -1);
      wait_done(20);
      check("t3_reload_done", done_cnt, 1);
      check("t3_reload_checksum", last_done_sum, 16'h0820);
      check_ramp("t3");
      idle(3);

      // T4: start+abort in IDLE ignored; start during LOAD ignored
      clear_stats();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("t4_busy", busy, 0);
      check("t4_cload", cload, 0);
      idle(3);
      check("t4_no_pulses", done_cnt + abt_cnt, 0);
      do_start();
      send_stream(NTAPS, 0, -1, 20);
      wait_done(20);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_abt_cnt", abt_cnt, 0);
      check("t4_checksum", last_done_sum, 16'h0820);
      check_ramp("t4");
      idle(3);

      // T5: all-ones words wrap the checksum; a 65th word is refused
      clear_stats();
      for (int i = 0; i < NTAPS; i++) words[i] = 16'hFFFF;
      do_start();
      send_stream(NTAPS, 0, -1, -1);
      s_valid = 1'b1;
      s_data  = 16'h1234;
      check("t5_ready_after_last", s_ready, 0);
      wait_done(20);
      s_valid = 1'b0;
      check("t5_checksum", last_done_sum, 16'hFFC0);
      check("t5_mem63", fir_mem[63], 16'hFFFF);
      check("t5_cin", cin, 16'hFFFF);
      check("t5_caddr", caddr, 63);
      idle(3);

      // T6: reset during HOLD
      clear_stats();
      fill_ramp();
      do_start();
      send_stream(NTAPS, 0, -1, -1);
      check("t6_in_hold", cload, 1);
      #2 rstn = 1'b0;
      #1;
      check("t6_cload_async", cload, 0);
      check("t6_busy_async", busy, 0);
      check("t6_ready_async", s_ready, 0);
      idle(2);
      rstn = 1'b1;
      idle(3);
      check("t6_no_pulses", done_cnt + abt_cnt, 0);
      check("t6_cin", cin, 0);
      check("t6_caddr", caddr, 0);
      check("t6_checksum", checksum, 0);
      check("t6_flags", {s_ready, cload, busy, load_done, aborted}, 5'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
